// File: rtl/usb_pio_pkg.sv
// Shared constants for the USB status-pin input PIO: register map, edge
// selection encodings and a constant-width helper.
package usb_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/usb_pio_debounce_bit.sv
// One input bit: multi-flop synchroniser followed by an optional
// stable-time debouncer that hides glitches shorter than DEBOUNCE_CYCLES.
module usb_pio_debounce_bit
    import usb_pio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic filt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
        end
    end

    always_comb sync_out = sync_q[SYNC_STAGES-1];

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        always_comb filt = sync_out;
    end else begin : g_debounce
        localparam int unsigned    CW   = clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

        logic [CW-1:0] count;
        logic          filt_q;

        // Toggle on the D-th consecutive mismatch; any agreement restarts the count.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                count  <= '0;
                filt_q <= 1'b0;
            end else if (sync_out == filt_q) begin
                count <= '0;
            end else if (count == LAST) begin
                filt_q <= ~filt_q;
                count  <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end

        always_comb filt = filt_q;
    end

endmodule

// File: rtl/usb_pio_in_edge.sv
// Avalon-MM input PIO for USB status pins: synchronised/debounced data,
// sticky edge capture with write-1-to-clear, and a maskable level irq.
module usb_pio_in_edge
    import usb_pio_pkg::*;
#(
    parameter int WIDTH           = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] edge_clear;
    logic [WIDTH-1:0] irq_mask;
    logic             wr_en;
    logic [31:0]      rd_next;
    logic [31:0]      unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        usb_pio_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .pin     (in_port[i]),
            .filt    (filt[i])
        );
    end

    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALL: edges = ~filt & prev;
            EDGE_ANY:  edges = filt ^ prev;
            default:   edges = filt & ~prev;
        endcase
    end

    // Upper write bits have no register behind them.
    always_comb unused_wdata = writedata;

    always_comb begin
        wr_en      = chipselect & ~write_n;
        edge_clear = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    end

    // A fresh edge is OR-ed in after the clear, so set wins a collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev         <= '0;
            edge_capture <= '0;
            irq_mask     <= '0;
        end else begin
            prev         <= filt;
            edge_capture <= (edge_capture & ~edge_clear) | edges;
            if (wr_en && address == ADDR_MASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA: rd_next = 32'(filt);
            ADDR_RSVD: rd_next = '0;
            ADDR_MASK: rd_next = 32'(irq_mask);
            ADDR_EDGE: rd_next = 32'(edge_capture);
            default:   rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

    always_comb irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_usb_pio_in_edge.sv
// Three PIO configurations share one bus and pin stimulus; each is checked
// every cycle against a behavioural pin-history / stable-time model.
module tb_usb_pio_in_edge;

    localparam int W  = 4;
    localparam int ND = 3;
    localparam int HD = 8;
    localparam int S_P [ND] = '{2, 2, 3};
    localparam int D_P [ND] = '{0, 3, 8};
    localparam int E_P [ND] = '{0, 1, 2};

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   rd0, rd1, rd2;
    logic          irq0, irq1, irq2;

    usb_pio_in_edge #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0));

    usb_pio_in_edge #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(3), .EDGE_TYPE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd1), .irq(irq1));

    usb_pio_in_edge #(.WIDTH(W), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd2), .irq(irq2));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: pin history (age 0 = newest sample), per-bit mismatch run lengths.
    logic [W-1:0] hist   [ND][HD];
    int           run    [ND][W];
    logic [W-1:0] m_filt [ND];
    logic [W-1:0] m_prev [ND];
    logic [W-1:0] m_edge [ND];
    logic [W-1:0] m_mask [ND];
    logic [31:0]  m_rd   [ND];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_of(input int k);
        if (k == 0) return rd0;
        if (k == 1) return rd1;
        return rd2;
    endfunction

    function automatic logic irq_of(input int k);
        if (k == 0) return irq0;
        if (k == 1) return irq1;
        return irq2;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < ND; k++) begin
            for (int a = 0; a < HD; a++) hist[k][a] = '0;
            for (int b = 0; b < W; b++) run[k][b] = 0;
            m_filt[k] = '0;
            m_prev[k] = '0;
            m_edge[k] = '0;
            m_mask[k] = '0;
            m_rd[k]   = '0;
        end
    endtask

    task automatic model_edge();
        logic [W-1:0] s_old, f_old, p_old, ev, clr;
        logic         wr;
        wr = chipselect && !write_n;
        for (int k = 0; k < ND; k++) begin
            s_old = hist[k][S_P[k]-1];
            f_old = m_filt[k];
            p_old = m_prev[k];
            case (E_P[k])
                0:       ev = f_old & ~p_old;
                1:       ev = ~f_old & p_old;
                default: ev = f_old ^ p_old;
            endcase
            case (address)
                2'd0:    m_rd[k] = 32'(f_old);
                2'd2:    m_rd[k] = 32'(m_mask[k]);
                2'd3:    m_rd[k] = 32'(m_edge[k]);
                default: m_rd[k] = '0;
            endcase
            clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
            m_edge[k] = (m_edge[k] & ~clr) | ev;
            if (wr && address == 2'd2) m_mask[k] = writedata[W-1:0];
            m_prev[k] = f_old;
            for (int a = HD-1; a > 0; a--) hist[k][a] = hist[k][a-1];
            hist[k][0] = in_port;
            if (D_P[k] == 0) begin
                m_filt[k] = hist[k][S_P[k]-1];
            end else begin
                for (int b = 0; b < W; b++) begin
                    if (s_old[b] != f_old[b]) begin
                        run[k][b]++;
                        if (run[k][b] == D_P[k]) begin
                            m_filt[k][b] = ~f_old[b];
                            run[k][b] = 0;
                        end
                    end else begin
                        run[k][b] = 0;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("readdata[%0d]", k), rd_of(k), m_rd[k]);
            chk($sformatf("irq[%0d]", k), 32'(irq_of(k)), 32'(|(m_edge[k] & m_mask[k])));
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        step();
        write_n    = 1'b1;
    endtask

    task automatic settle(input logic [W-1:0] pins, input int n);
        in_port = pins;
        repeat (n) step();
    endtask

    int hold;

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        model_reset();
        #22;
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("reset_rd[%0d]", k), rd_of(k), 32'h0);
            chk($sformatf("reset_irq[%0d]", k), 32'(irq_of(k)), 32'h0);
        end
        reset_n = 1'b1;

        // Data read latency: pins before edge 1 visible in readdata at edge 3.
        chipselect = 1'b1;
        address    = 2'd0;
        in_port    = 4'b1010;
        step(); step();
        chk("data_lat_early", rd0, 32'h0);
        step();
        chk("data_lat", rd0, 32'h0000000A);
        address = 2'd1;
        step();
        chk("rsvd_read", rd0, 32'h0);

        // Rising edge capture, irq timing, write-1-to-clear.
        settle(4'b0000, 14);
        bus_write(2'd3, 32'hF);
        bus_write(2'd2, 32'h2);
        address = 2'd3;
        in_port = 4'b0010;
        step(); step();
        chk("irq_early", 32'(irq0), 32'h0);
        step();
        chk("irq_set", 32'(irq0), 32'h1);
        step();
        chk("edge_bit1", rd0, 32'h2);
        bus_write(2'd3, 32'h2);
        chk("irq_clear", 32'(irq0), 32'h0);
        step();
        chk("edge_cleared", rd0, 32'h0);

        // Set wins over a same-cycle clear.
        settle(4'b0000, 14);
        bus_write(2'd3, 32'hF);
        address = 2'd3;
        in_port = 4'b0001;
        step(); step();
        bus_write(2'd3, 32'h1);
        step();
        chk("collide", rd0 & 32'h1, 32'h1);

        // D=8 debounce: short glitch filtered, long pulse passes after 8 clocks.
        settle(4'b0000, 16);
        bus_write(2'd3, 32'hF);
        address = 2'd3;
        settle(4'b0001, 5);
        settle(4'b0000, 20);
        chk("glitch_edge", rd2, 32'h0);
        address = 2'd0;
        step();
        chk("glitch_data", rd2, 32'h0);
        in_port = 4'b0001;
        repeat (11) step();
        chk("deb_data_early", rd2 & 32'h1, 32'h0);
        step();
        chk("deb_data", rd2 & 32'h1, 32'h1);

        // Any-edge with mask 0, then unmask over a captured bit.
        settle(4'b0000, 16);
        bus_write(2'd2, 32'h0);
        bus_write(2'd3, 32'hF);
        settle(4'b1000, 14);
        settle(4'b0000, 14);
        address = 2'd3;
        step();
        chk("any_edge", rd2, 32'h8);
        chk("any_irq_masked", 32'(irq2), 32'h0);
        bus_write(2'd2, 32'h8);
        chk("any_irq_unmask", 32'(irq2), 32'h1);
        bus_write(2'd2, 32'hFFFF_FFFF);
        step();
        chk("mask_readback", rd2, 32'hF);

        // Randomised pins with variable hold times and random bus traffic.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                in_port = W'($urandom);
                hold    = $urandom_range(1, 14);
            end
            hold--;
            chipselect = ($urandom_range(0, 3) != 0);
            write_n    = ($urandom_range(0, 3) != 0);
            address    = 2'($urandom);
            writedata  = $urandom;
            step();
        end
        write_n = 1'b1;

        // Reset in the middle of a debounce interval with all edges captured.
        chipselect = 1'b1;
        bus_write(2'd2, 32'hF);
        settle(4'b0000, 16);
        bus_write(2'd3, 32'hF);
        address = 2'd3;
        settle(4'b1111, 14);
        chk("pre_reset_edge", rd0, 32'hF);
        settle(4'b0000, 4);
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("midreset_rd[%0d]", k), rd_of(k), 32'h0);
            chk($sformatf("midreset_irq[%0d]", k), 32'(irq_of(k)), 32'h0);
        end
        @(posedge clk);
        #4;
        reset_n = 1'b1;
        repeat (20) step();
        address = 2'd2;
        step();
        chk("post_reset_mask", rd2, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
